// File: rtl/serial_sub_pkg.sv
// Shared constants and FSM state type for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - b_in with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor, LSB first, one bit per clock: {b_out, d} = a - b - b_in.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow flag ovf.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting one operand bit per cycle, WIDTH cycles
// DONE  | result valid, done high; start here begins the next operation
module serial_subtractor4
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             load, last;
  logic             diff_bit, br_nxt;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .b_in (br),
    .d    (diff_bit),
    .b_out(br_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          state_d = DONE;
          last    = 1'b1;
        end
      end
      DONE: begin
        load    = start;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // Result bits enter at the MSB so that after WIDTH shifts the LSB lands in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      b_out  <= 1'b0;
    end else if (load) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      br     <= b_in;
      cnt    <= '0;
    end else if (state_q == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {diff_bit, res_sh[WIDTH-1:1]};
      br     <= br_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        d     <= {diff_bit, res_sh[WIDTH-1:1]};
        b_out <= br_nxt;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_sgn, b_sgn;

  // Operand signs are kept at capture; on the last bit diff_bit is the result sign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sgn <= 1'b0;
      b_sgn <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_sgn <= a[WIDTH-1];
      b_sgn <= b[WIDTH-1];
    end else if (last) begin
      ovf <= (a_sgn != b_sgn) && (diff_bit != a_sgn);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor4.sv
// Self-checking bench for serial_subtractor4: directed cases, exhaustive sweep, random ops.
module tb_serial_subtractor4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         b_in;
  logic         busy, done;
  logic [W-1:0] d;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
  logic         exp_ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_d;
  logic         exp_bo;

  serial_subtractor4 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .b_in (b_in),
    .busy (busy),
    .done (done),
    .d    (d),
    .b_out(b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Call at a negedge; returns #1 after the accepting edge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    start = 1'b1;
    a     = av;
    b     = bv;
    b_in  = bi;
    @(posedge clk);
    #1;
  endtask

  // Runs the remaining RUN cycles with scrambled inputs, then checks the result.
  task automatic finish_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                           input bit pulse_mid);
    int diff;
    logic [W:0] r;
    diff = int'(av) - int'(bv) - int'(bi);
    r    = diff[W:0];
    for (int i = 0; i < W; i++) begin
      check("busy_run", int'(busy), 1);
      check("done_early", int'(done), 0);
      check("d_hold", int'(d), int'(exp_d));
      check("bout_hold", int'(b_out), int'(exp_bo));
      @(negedge clk);
      a     = W'($urandom);
      b     = W'($urandom);
      b_in  = 1'($urandom);
      start = pulse_mid && (i == 1);
      @(posedge clk);
      #1;
    end
    exp_d  = r[W-1:0];
    exp_bo = r[W];
    check("done", int'(done), 1);
    check("busy_done", int'(busy), 0);
    check("d", int'(d), int'(exp_d));
    check("b_out", int'(b_out), int'(exp_bo));
`ifdef SERIAL_SUB_OVF_EN
    exp_ovf = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
    check("ovf", int'(ovf), int'(exp_ovf));
`endif
  endtask

  task automatic go_idle();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_single", int'(done), 0);
    check("busy_idle", int'(busy), 0);
    check("d_idle", int'(d), int'(exp_d));
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    @(negedge clk);
    launch(av, bv, bi);
    finish_op(av, bv, bi, 1'b0);
    go_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    exp_d = '0; exp_bo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_d", int'(d), 0);
    check("rst_bout", int'(b_out), 0);

    // First start on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    launch(4'd2, 4'd3, 1'b0);
    finish_op(4'd2, 4'd3, 1'b0, 1'b0);
    check("r030_d", int'(d), 15);
    go_idle();

    // Back-to-back from DONE.
    @(negedge clk);
    launch(4'd3, 4'd2, 1'b1);
    finish_op(4'd3, 4'd2, 1'b1, 1'b0);
    check("r031_d0", int'(d), 0);
    @(negedge clk);
    launch(4'd0, 4'd0, 1'b1);
    finish_op(4'd0, 4'd0, 1'b1, 1'b0);
    check("r031_d15", int'(d), 15);
    check("r031_bout", int'(b_out), 1);
    go_idle();

    // Start pulsed mid-RUN, inputs scrambled.
    @(negedge clk);
    launch(4'd8, 4'd7, 1'b0);
    finish_op(4'd8, 4'd7, 1'b0, 1'b1);
    check("r032_d", int'(d), 1);
    go_idle();

    // Reset during the second RUN cycle aborts.
    @(negedge clk);
    launch(4'd9, 4'd4, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_d = '0; exp_bo = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_d", int'(d), 0);
    check("abort_bout", int'(b_out), 0);
    start = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      check("abort_nodone", int'(done), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    launch(4'd9, 4'd4, 1'b0);
    finish_op(4'd9, 4'd4, 1'b0, 1'b0);
    check("r033_d", int'(d), 5);
    go_idle();

`ifdef SERIAL_SUB_OVF_EN
    do_op(4'd8, 4'd1, 1'b0);
    check("r034_ovf1", int'(ovf), 1);
    do_op(4'd5, 4'd3, 1'b0);
    check("r034_ovf0", int'(ovf), 0);
`endif

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          do_op(W'(ai), W'(bi), 1'(ci));

    // Random operations with random back-to-back chaining and mid-RUN start pulses.
    begin
      logic [W-1:0] ra, rb;
      logic         rc;
      @(negedge clk);
      for (int k = 0; k < 200; k++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom);
        launch(ra, rb, rc);
        finish_op(ra, rb, rc, 1'($urandom));
        if ($urandom_range(0, 1) == 0) go_idle();
        @(negedge clk);
      end
      start = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
